// File: rtl/aes_dma_sequencer.sv
// APB master that moves words between the stream fabric and the AES data registers,
// driven by the AES per-word DMA request pulses, and reports completion per block count.
module aes_dma_sequencer #(
  parameter logic [3:0] DINR_ADDR  = 4'h2,
  parameter logic [3:0] DOUTR_ADDR = 4'h3,
  parameter int         BLK_W      = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             start,
  input  logic             abort,
  input  logic [BLK_W-1:0] cfg_blocks,
  input  logic             dma_req_wr,
  input  logic             dma_req_rd,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       PADDR,
  output logic [31:0]      PWDATA,
  output logic             PWRITE,
  output logic             PSEL,
  output logic             PENABLE,
  input  logic [31:0]      PRDATA,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
);

  localparam int CNT_W = BLK_W + 2;

  typedef enum logic [2:0] {
    IDLE, WAIT, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS, R_CAPTURE, R_PUSH
  } state_t;

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   blocks_q, blocks_d;
  logic [CNT_W-1:0]   wr_words_q, wr_words_d;
  logic [CNT_W-1:0]   rd_words_q, rd_words_d;
  logic               pend_wr_q, pend_wr_d;
  logic               pend_rd_q, pend_rd_d;
  logic               err_ovf_q, err_ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;
  logic [3:0]         paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [31:0]        out_data_q, out_data_d;

  logic [CNT_W-1:0]   target;
  logic               wr_accept;
  logic               rd_accept;
  logic               abort_seen;
  logic               abort_exit;

  always_comb begin
    state_d    = state_q;
    blocks_d   = blocks_q;
    wr_words_d = wr_words_q;
    rd_words_d = rd_words_q;
    err_ovf_d  = err_ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    abort_exit = 1'b0;

    target     = {blocks_q, 2'b00};
    abort_seen = abort_q | abort;
    // Requests only count while a run is active; input requests stop once all words are written.
    wr_accept  = dma_req_wr && (state_q != IDLE) && (wr_words_q != target);
    rd_accept  = dma_req_rd && (state_q != IDLE);

    if ((wr_accept && pend_wr_q) || (rd_accept && pend_rd_q)) begin
      err_ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          blocks_d   = cfg_blocks;
          wr_words_d = '0;
          rd_words_d = '0;
          err_ovf_d  = 1'b0;
          if (cfg_blocks == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          abort_exit = 1'b1;
          state_d    = IDLE;
        end else if (pend_rd_q) begin
          paddr_d = DOUTR_ADDR;
          state_d = R_SETUP;
        end else if (pend_wr_q && in_valid) begin
          in_ready = 1'b1;
          pwdata_d = in_data;
          paddr_d  = DINR_ADDR;
          state_d  = W_SETUP;
        end
      end
      W_SETUP:  state_d = W_ACCESS;
      W_ACCESS: begin
        wr_words_d = wr_words_q + 1'b1;
        if (abort_seen) begin
          abort_exit = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      R_SETUP:  state_d = R_ACCESS;
      R_ACCESS: state_d = R_CAPTURE;
      R_CAPTURE: begin
        // The slave presents PRDATA one cycle after the access phase.
        if (abort_seen) begin
          abort_exit = 1'b1;
          state_d    = IDLE;
        end else begin
          out_data_d = PRDATA;
          state_d    = R_PUSH;
        end
      end
      R_PUSH: begin
        if (abort) begin
          abort_exit = 1'b1;
          state_d    = IDLE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            rd_words_d = rd_words_q + 1'b1;
            if (rd_words_d == target) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request in the same cycle as the clear keeps the flag set.
    pend_wr_d = wr_accept | (pend_wr_q & ~((state_q == WAIT) && (state_d == W_SETUP)));
    pend_rd_d = rd_accept | (pend_rd_q & ~((state_q == WAIT) && (state_d == R_SETUP)));
    if (abort_exit) begin
      pend_wr_d = 1'b0;
      pend_rd_d = 1'b0;
      busy_d    = 1'b0;
    end
    abort_d = abort_seen && (state_q != IDLE) && (state_d != IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      blocks_q   <= '0;
      wr_words_q <= '0;
      rd_words_q <= '0;
      pend_wr_q  <= 1'b0;
      pend_rd_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      blocks_q   <= blocks_d;
      wr_words_q <= wr_words_d;
      rd_words_q <= rd_words_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      err_ovf_q  <= err_ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      out_data_q <= out_data_d;
    end
  end

  assign PSEL     = (state_q == W_SETUP) || (state_q == W_ACCESS) ||
                    (state_q == R_SETUP) || (state_q == R_ACCESS);
  assign PENABLE  = (state_q == W_ACCESS) || (state_q == R_ACCESS);
  assign PWRITE   = (state_q == W_SETUP) || (state_q == W_ACCESS);
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign out_data = out_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_aes_dma_sequencer.sv
// Randomized bench for aes_dma_sequencer: APB slave, stream source/sink and a queue-based
// reference of words written, words returned and completion pulses.
module tb_aes_dma_sequencer;

  localparam int BLK_W = 16;

  logic             PCLK = 1'b0;
  logic             PRESETn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [BLK_W-1:0] cfg_blocks = '0;
  logic             dma_req_wr = 1'b0;
  logic             dma_req_rd = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       PADDR;
  logic [31:0]      PWDATA;
  logic             PWRITE;
  logic             PSEL;
  logic             PENABLE;
  logic [31:0]      PRDATA = '0;
  logic             busy;
  logic             done;
  logic             err_ovf;

  aes_dma_sequencer #(.DINR_ADDR(4'h2), .DOUTR_ADDR(4'h3), .BLK_W(BLK_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .abort(abort), .cfg_blocks(cfg_blocks),
    .dma_req_wr(dma_req_wr), .dma_req_rd(dma_req_rd),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .busy(busy), .done(done), .err_ovf(err_ovf)
  );

  always #5 PCLK = ~PCLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          apb_cnt = 0;
  logic [31:0] in_q[$], rd_src[$], exp_wr[$], exp_rd[$], wr_log[$], got_q[$];
  bit          acc_log[$];
  bit          bp_in = 1'b0;
  bit          bp_out = 1'b0;
  logic        prev_setup = 1'b0;
  logic [3:0]  prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stream source and sink, driven away from the active edge.
  always @(negedge PCLK) begin
    in_valid  = (in_q.size() > 0) && !bp_in && ($urandom_range(0, 3) != 0);
    in_data   = (in_q.size() > 0) ? in_q[0] : 32'h0;
    out_ready = !bp_out && ($urandom_range(0, 3) != 0);
  end

  // APB slave with registered read data, plus transaction monitor.
  always @(posedge PCLK) begin
    if (PSEL && PENABLE) begin
      chk("apb_setup_first", {31'b0, prev_setup}, 32'd1);
      chk("apb_addr_stable", {28'b0, PADDR}, {28'b0, prev_addr});
      apb_cnt++;
      if (PWRITE) begin
        chk("wr_addr", {28'b0, PADDR}, 32'h2);
        wr_log.push_back(PWDATA);
        acc_log.push_back(1'b1);
      end else begin
        chk("rd_addr", {28'b0, PADDR}, 32'h3);
        acc_log.push_back(1'b0);
        PRDATA <= (rd_src.size() > 0) ? rd_src.pop_front() : 32'hDEAD_BEEF;
      end
    end
    if (in_valid && in_ready && in_q.size() > 0) void'(in_q.pop_front());
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (done) done_cnt++;
    prev_setup <= PSEL && !PENABLE;
    prev_addr  <= PADDR;
  end

  task automatic pulse(input bit w, input bit r);
    @(negedge PCLK);
    dma_req_wr = w;
    dma_req_rd = r;
    @(negedge PCLK);
    dma_req_wr = 1'b0;
    dma_req_rd = 1'b0;
  endtask

  task automatic wait_wr(input int tgt);
    for (int c = 0; c < 300 && wr_log.size() < tgt; c++) @(negedge PCLK);
    chk("wr_count", wr_log.size(), tgt);
  endtask

  task automatic wait_out(input int tgt);
    for (int c = 0; c < 300 && got_q.size() < tgt; c++) @(negedge PCLK);
    chk("out_count", got_q.size(), tgt);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge PCLK);
  endtask

  task automatic clear_logs();
    in_q.delete(); rd_src.delete(); exp_wr.delete(); exp_rd.delete();
    wr_log.delete(); got_q.delete(); acc_log.delete();
  endtask

  task automatic start_run(input int nb);
    @(negedge PCLK);
    cfg_blocks = nb[BLK_W-1:0];
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    chk("busy_after_start", busy, (nb != 0));
    chk("err_cleared_by_start", err_ovf, 0);
  endtask

  task automatic do_write(input logic [31:0] w);
    in_q.push_back(w);
    exp_wr.push_back(w);
    pulse(1'b1, 1'b0);
    wait_wr(exp_wr.size());
    gap();
  endtask

  task automatic do_read(input logic [31:0] r, input bit last);
    rd_src.push_back(r);
    exp_rd.push_back(r);
    pulse(1'b0, 1'b1);
    wait_out(exp_rd.size());
    chk("done_pulse", done, last);
    gap();
  endtask

  task automatic check_logs();
    chk("wr_total", wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) chk("wr_data", wr_log[i], exp_wr[i]);
    chk("rd_total", got_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < got_q.size(); i++) chk("rd_data", got_q[i], exp_rd[i]);
  endtask

  task automatic finish_run(input int d0);
    @(negedge PCLK);
    chk("busy_end", busy, 0);
    chk("done_count", done_cnt, d0 + 1);
    check_logs();
  endtask

  task automatic run_blocks(input int nb, input bit directed);
    int d0;
    clear_logs();
    start_run(nb);
    d0 = done_cnt;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 4; i++) do_write(directed ? 32'hA0 + 4*b + i : $urandom);
      for (int i = 0; i < 4; i++) do_read(directed ? 32'hB0 + 4*b + i : $urandom, (b == nb-1) && (i == 3));
    end
    finish_run(d0);
  endtask

  initial begin
    int d0;
    int a0;
    int base;
    logic [31:0] held;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // Zero blocks: immediate completion, no bus activity
    a0 = apb_cnt;
    @(negedge PCLK);
    cfg_blocks = '0;
    start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge PCLK);
    chk("zero_done_once", done, 0);
    repeat (3) @(negedge PCLK);
    chk("zero_apb", apb_cnt, a0);

    // Directed single block
    run_blocks(1, 1'b1);

    // Read wins over a simultaneous write request
    clear_logs();
    start_run(1);
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) do_write($urandom);
    in_q.push_back(32'h5555_0003); exp_wr.push_back(32'h5555_0003);
    rd_src.push_back(32'h6666_0000); exp_rd.push_back(32'h6666_0000);
    base = acc_log.size();
    pulse(1'b1, 1'b1);
    for (int c = 0; c < 300 && acc_log.size() < base + 2; c++) @(negedge PCLK);
    chk("prio_accesses", acc_log.size(), base + 2);
    if (acc_log.size() >= base + 2) begin
      chk("prio_first_is_read", acc_log[base], 0);
      chk("prio_then_write", acc_log[base+1], 1);
    end
    wait_wr(4);
    wait_out(1);
    for (int i = 0; i < 3; i++) do_read($urandom, i == 2);
    finish_run(d0);

    // Backpressure on both streams
    clear_logs();
    start_run(1);
    d0 = done_cnt;
    bp_in = 1'b1;
    in_q.push_back(32'h1234_0000); exp_wr.push_back(32'h1234_0000);
    pulse(1'b1, 1'b0);
    repeat (5) begin
      @(negedge PCLK);
      chk("bp_in_no_psel", PSEL, 0);
    end
    bp_in = 1'b0;
    wait_wr(1);
    for (int i = 0; i < 3; i++) do_write($urandom);
    bp_out = 1'b1;
    rd_src.push_back(32'hC0DE_0000); exp_rd.push_back(32'hC0DE_0000);
    pulse(1'b0, 1'b1);
    for (int c = 0; c < 100 && !out_valid; c++) @(negedge PCLK);
    chk("bp_out_valid_seen", out_valid, 1);
    held = out_data;
    repeat (3) begin
      @(negedge PCLK);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_out_data_stable", out_data, held);
      chk("bp_out_no_count", got_q.size(), 0);
    end
    bp_out = 1'b0;
    wait_out(1);
    for (int i = 0; i < 3; i++) do_read($urandom, i == 2);
    finish_run(d0);

    // Overflow: two write requests before the first transfer
    clear_logs();
    start_run(1);
    d0 = done_cnt;
    bp_in = 1'b1;
    in_q.push_back(32'h0F0F_0000); exp_wr.push_back(32'h0F0F_0000);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("ovf_flag", err_ovf, 1);
    bp_in = 1'b0;
    wait_wr(1);
    repeat (8) @(negedge PCLK);
    chk("ovf_single_write", wr_log.size(), 1);
    for (int i = 0; i < 3; i++) do_write($urandom);
    for (int i = 0; i < 4; i++) do_read($urandom, i == 3);
    chk("ovf_sticky", err_ovf, 1);
    finish_run(d0);

    // Abort during the write access phase (start also clears the overflow flag)
    clear_logs();
    start_run(1);
    d0 = done_cnt;
    a0 = apb_cnt;
    in_q.push_back(32'hAB0A_0000); exp_wr.push_back(32'hAB0A_0000);
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 100 && !(PSEL && PENABLE && PWRITE); c++) @(negedge PCLK);
    chk("abort_reach_access", PSEL && PENABLE && PWRITE, 1);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_psel", PSEL, 0);
    repeat (4) @(negedge PCLK);
    chk("abort_one_access", apb_cnt, a0 + 1);
    chk("abort_no_done", done_cnt, d0);
    check_logs();

    // Asynchronous reset in the middle of a read access
    clear_logs();
    start_run(1);
    rd_src.push_back(32'hEEEE_0000);
    pulse(1'b0, 1'b1);
    for (int c = 0; c < 100 && !(PSEL && PENABLE && !PWRITE); c++) @(negedge PCLK);
    chk("rst_reach_raccess", PSEL && PENABLE && !PWRITE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    run_blocks(2, 1'b0);
    run_blocks(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
